universal_shift_reg_n: RTL and testbench
========================================

Name: universal_shift_reg_n

Overview:
- Parametrised, multi-mode universal shift register and the next generation of the team's 4-bit universal shift register.
- Extends it in three ways: configurable WIDTH, rotate and arithmetic-shift modes, and multi-bit shifts driven by a start/busy/done sequencer (one bit per clock).
- Used as a serial/parallel converter and barrel-shift substitute in datapaths where area matters more than latency.
- Keeps the original serial-port convention: s_right_din enters at the MSB, s_left_din enters at the LSB.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of the shift-amount input; maximum amount is 2^AMT_W-1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; highest priority after rst_n.
- start  input  1  begin operation; sampled only when busy=0.
- op  input  3  operation code, latched at the start edge.
- amt  input  AMT_W  shift/rotate count, latched at the start edge.
- p_din  input  WIDTH  parallel load data.
- s_left_din  input  1  serial input for SHL, enters at the LSB.
- s_right_din  input  1  serial input for SHR, enters at the MSB.
- p_dout  output  WIDTH  register contents (registered).
- s_left_dout  output  1  equals p_dout[0].
- s_right_dout  output  1  equals p_dout[WIDTH-1].
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: rst_n low asynchronously forces p_dout=0, busy=0, done=0, count=0 and state IDLE, even mid-operation.
- op codes:
  - 0 HOLD.
  - 1 SHR: {s_right_din, p[W-1:1]}.
  - 2 SHL: {p[W-2:0], s_left_din}.
  - 3 LOAD: p_din.
  - 4 ROR: {p[0], p[W-1:1]}.
  - 5 ROL: {p[W-2:0], p[W-1]}.
  - 6 ASR: {p[W-1], p[W-1:1]}.
  - 7 is reserved and behaves exactly as HOLD.
- FSM states are IDLE and SHIFT.
- IDLE with start=1:
  - LOAD: p_dout<=p_din at that edge; done=1 for the next cycle; busy stays 0.
  - HOLD/reserved, or any shift op with amt=0: p_dout unchanged; done=1 for the next cycle; busy stays 0.
  - Shift op with amt=N>=1: the first single-bit step happens at the start edge.
    - If N=1: done=1 next cycle, stay IDLE.
    - Otherwise: latch op, count<=N-1, busy<=1, go to SHIFT.
- SHIFT: one step per edge, count decrements.
  - At the edge where count goes 1->0: perform the last step, busy<=0, done<=1, return to IDLE.
  - Total: N update edges; busy high for N-1 cycles; done coincides with the cycle after the final update.
- Serial inputs are sampled live at every step, not latched at start.
- amt counts literally, with no clamp. SHR/SHL with N>=WIDTH fully replaces the contents with serial data; ROR/ROL with N=WIDTH restores the original value.
- start while busy=1 is ignored. op, amt and p_din changes during SHIFT have no effect.
- done is high for exactly one cycle. start in the same cycle that done is high is accepted normally, because busy is already 0.
- clr=1 at an edge: p_dout<=0, busy<=0, count<=0, IDLE, no done pulse. clr wins over a simultaneous start.
- s_left_dout and s_right_dout are combinational taps of the p_dout register; no other output has combinational paths from inputs.

Test Plan (WIDTH=8, AMT_W=4):
- Reset, then LOAD p_din=0xA5 -> p_dout=0xA5 after the edge; done=1 for one cycle; busy never high; s_left_dout=1, s_right_dout=1.
- From 0xA5, ROR amt=3 -> p_dout 0xD2, 0x69, 0xB4 on successive edges; busy high 2 cycles; done one cycle after 0xB4 appears. Then ROL amt=8 -> 0xB4 again.
- LOAD 0x90, then ASR amt=4 -> 0xF9. LOAD 0x0F, then SHL amt=2 with s_left_din=1 -> 0x3F. SHR amt=0 -> 0x3F unchanged, done pulse.
- LOAD 0x00, then SHR amt=8 with s_right_din toggling 1,0,1,0,... starting at the start edge -> 0x55; s_left_dout follows p_dout[0] each cycle.
- During ROR amt=5, assert start with op=LOAD -> ignored, result equals ROR by 5. During a later ROR amt=5, pulse clr at step 2 -> p_dout=0, busy=0, no done.
- During SHL amt=6, drop rst_n between clock edges -> p_dout, busy and done go to 0 immediately. After release, LOAD 0x3C works normally.

Source files
------------

// File: rtl/universal_shift_reg_n.sv
// universal_shift_reg_n: parametrised universal shift register with multi-bit sequenced shifts
//
// Shift, rotate and arithmetic-shift operations move one bit per clock.
// A shift by N takes N update edges, and the first step happens on the start edge.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   clr          : synchronous clear; wins over start and aborts an operation without a done pulse
//   start        : begin an operation; ignored while busy
//   op           : 0 HOLD, 1 SHR, 2 SHL, 3 LOAD, 4 ROR, 5 ROL, 6 ASR, 7 HOLD
//   amt          : step count for shift ops; latched at start
//   p_din        : parallel load data
//   s_left_din   : serial input for SHL, enters at the LSB
//   s_right_din  : serial input for SHR, enters at the MSB
//   p_dout       : register contents
//   s_left_dout  : p_dout[0]
//   s_right_dout : p_dout[WIDTH-1]
//   busy         : a multi-cycle operation is in progress
//   done         : one-cycle completion pulse
module universal_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] p_din,
    input  logic             s_left_din,
    input  logic             s_right_din,
    output logic [WIDTH-1:0] p_dout,
    output logic             s_left_dout,
    output logic             s_right_dout,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_LOAD = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic [AMT_W-1:0]   count_q, count_d;
    logic [2:0]         op_q, op_d;
    logic               done_q, done_d;

    logic [2:0]         sop;
    logic [WIDTH-1:0]   step;
    logic               is_shift;

    // In IDLE the first step uses the live op; during SHIFT the latched op is used.
    assign sop      = (state_q == SHIFT) ? op_q : op;
    assign is_shift = (sop != OP_HOLD) && (sop != OP_LOAD) && (sop != OP_RSVD);

    always_comb begin
        step = (sop == OP_SHR) ? {s_right_din, p_q[WIDTH-1:1]} :
               (sop == OP_SHL) ? {p_q[WIDTH-2:0], s_left_din}  :
               (sop == OP_ROR) ? {p_q[0], p_q[WIDTH-1:1]}      :
               (sop == OP_ROL) ? {p_q[WIDTH-2:0], p_q[WIDTH-1]} :
               (sop == OP_ASR) ? {p_q[WIDTH-1], p_q[WIDTH-1:1]} : p_q;
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        count_d = count_q;
        op_d    = op_q;
        done_d  = 1'b0;
        if (clr) begin
            state_d = IDLE;
            p_d     = '0;
            count_d = '0;
        end else if (state_q == SHIFT) begin
            p_d     = step;
            count_d = count_q - AMT_W'(1);
            if (count_q == AMT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (start) begin
            // Single-edge operations (LOAD, HOLD, amt of 0 or 1) complete immediately.
            done_d = 1'b1;
            if (op == OP_LOAD) begin
                p_d = p_din;
            end else if (is_shift && (amt != '0)) begin
                p_d = step;
                if (amt != AMT_W'(1)) begin
                    done_d  = 1'b0;
                    op_d    = op;
                    count_d = amt - AMT_W'(1);
                    state_d = SHIFT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            count_q <= '0;
            op_q    <= OP_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            count_q <= count_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    assign p_dout       = p_q;
    assign s_left_dout  = p_q[0];
    assign s_right_dout = p_q[WIDTH-1];
    assign busy         = (state_q == SHIFT);
    assign done         = done_q;
endmodule

// File: tb/tb_universal_shift_reg_n.sv
// tb_universal_shift_reg_n: directed self-checking bench for universal_shift_reg_n (WIDTH=8, AMT_W=4)
module tb_universal_shift_reg_n;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [3:0] amt = 4'd0;
    logic [7:0] p_din = 8'd0;
    logic       s_left_din = 1'b0;
    logic       s_right_din = 1'b0;
    logic [7:0] p_dout;
    logic       s_left_dout, s_right_dout, busy, done;

    int checks = 0;
    int errors = 0;

    universal_shift_reg_n #(.WIDTH(8), .AMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .op(op), .amt(amt),
        .p_din(p_din), .s_left_din(s_left_din), .s_right_din(s_right_din),
        .p_dout(p_dout), .s_left_dout(s_left_dout), .s_right_dout(s_right_dout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge for sampling and driving.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a start pulse on the next edge.
    task automatic go(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d);
        start = 1'b1; op = o; amt = a; p_din = d;
        cyc();
        start = 1'b0;
    endtask

    logic [7:0] exp_p;

    initial begin
        @(negedge clk);
        chk("rst p_dout", p_dout, 8'h00);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        rst_n = 1'b1;
        cyc();

        go(3'd3, 4'd0, 8'hA5);
        chk("load p_dout", p_dout, 8'hA5);
        chk("load done", done, 1'b1);
        chk("load busy", busy, 1'b0);
        chk("load s_left_dout", s_left_dout, 1'b1);
        chk("load s_right_dout", s_right_dout, 1'b1);

        // ROR by 3 started in the cycle where done is still high
        go(3'd4, 4'd3, 8'h00);
        chk("ror1 p_dout", p_dout, 8'hD2);
        chk("ror1 busy", busy, 1'b1);
        chk("ror1 done", done, 1'b0);
        cyc();
        chk("ror2 p_dout", p_dout, 8'h69);
        chk("ror2 busy", busy, 1'b1);
        cyc();
        chk("ror3 p_dout", p_dout, 8'hB4);
        chk("ror3 busy", busy, 1'b0);
        chk("ror3 done", done, 1'b1);
        cyc();
        chk("ror done width", done, 1'b0);

        go(3'd5, 4'd8, 8'h00);
        chk("rol8 first", p_dout, 8'h69);
        for (int i = 0; i < 6; i++) cyc();
        chk("rol8 busy mid", busy, 1'b1);
        cyc();
        chk("rol8 p_dout", p_dout, 8'hB4);
        chk("rol8 done", done, 1'b1);
        chk("rol8 busy end", busy, 1'b0);
        cyc();

        go(3'd3, 4'd0, 8'h90);
        go(3'd6, 4'd4, 8'h00);
        for (int i = 0; i < 3; i++) cyc();
        chk("asr4 p_dout", p_dout, 8'hF9);
        chk("asr4 done", done, 1'b1);
        cyc();

        go(3'd3, 4'd0, 8'h0F);
        s_left_din = 1'b1;
        go(3'd2, 4'd2, 8'h00);
        cyc();
        s_left_din = 1'b0;
        chk("shl2 p_dout", p_dout, 8'h3F);
        chk("shl2 done", done, 1'b1);
        cyc();

        go(3'd1, 4'd0, 8'h00);
        chk("shr0 p_dout", p_dout, 8'h3F);
        chk("shr0 done", done, 1'b1);
        chk("shr0 busy", busy, 1'b0);
        cyc();

        go(3'd3, 4'd0, 8'h00);
        exp_p = 8'h00;
        start = 1'b1; op = 3'd1; amt = 4'd8;
        for (int i = 0; i < 8; i++) begin
            s_right_din = (i % 2 == 0);
            exp_p = {s_right_din, exp_p[7:1]};
            cyc();
            start = 1'b0;
            chk("shr8 step", p_dout, exp_p);
            chk("shr8 s_left_dout", s_left_dout, exp_p[0]);
        end
        s_right_din = 1'b0;
        chk("shr8 p_dout", p_dout, 8'h55);
        chk("shr8 done", done, 1'b1);
        cyc();

        go(3'd3, 4'd0, 8'h81);
        go(3'd4, 4'd5, 8'h00);
        start = 1'b1; op = 3'd3; p_din = 8'hFF;
        cyc();
        start = 1'b0;
        chk("ror5 ignore busy", busy, 1'b1);
        cyc(); cyc(); cyc();
        chk("ror5 p_dout", p_dout, 8'h0C);
        chk("ror5 done", done, 1'b1);
        cyc();

        go(3'd4, 4'd5, 8'h00);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr p_dout", p_dout, 8'h00);
        chk("clr busy", busy, 1'b0);
        chk("clr done", done, 1'b0);
        cyc();
        chk("clr no done", done, 1'b0);
        chk("clr stays", p_dout, 8'h00);

        s_left_din = 1'b1;
        go(3'd2, 4'd6, 8'h00);
        cyc();
        chk("shl6 pre-rst", p_dout, 8'h03);
        chk("shl6 pre-rst busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst p_dout", p_dout, 8'h00);
        chk("async rst busy", busy, 1'b0);
        chk("async rst done", done, 1'b0);
        s_left_din = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post-rst idle", busy, 1'b0);
        go(3'd3, 4'd0, 8'h3C);
        chk("post-rst load", p_dout, 8'h3C);
        chk("post-rst done", done, 1'b1);
        cyc();
        chk("post-rst done clr", done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
